// File: rtl/aes_wrap_pkg.sv
// rtl/aes_wrap_pkg.sv - shared widths, beat/result types and width helpers for the AES stream wrapper
package aes_wrap_pkg;

  localparam int AES_BLK_W = 128;
  localparam int AES_KEY_W = 128;
  localparam int AES_TAG_W = 4;

  typedef struct packed {
    logic [AES_BLK_W-1:0] plain;
    logic [AES_KEY_W-1:0] key;
    logic [AES_TAG_W-1:0] tag;
  } aes_beat_t;

  typedef struct packed {
    logic [AES_BLK_W-1:0] cipher;
    logic [AES_TAG_W-1:0] tag;
  } aes_res_t;

  function automatic int cnt_w(input int depth, input int latency);
    return $clog2(depth + latency + 2);
  endfunction

  function automatic int fifo_cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/AES_Encrypt.sv
// rtl/AES_Encrypt.sv - combinational AES-128 encryption core, ten rounds fully unrolled
module AES_Encrypt (
  input  logic [127:0] i_plain,
  input  logic [127:0] i_key,
  output logic [127:0] o_cipher
);

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] t;
    p = 8'h00;
    t = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ t;
      t = xtime(t);
    end
    return p;
  endfunction

  // S-box built from the field inverse (x^254) followed by the affine map
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] inv;
    logic [7:0] sq;
    inv = 8'h01;
    sq  = x;
    for (int i = 1; i < 8; i++) begin
      sq  = gmul(sq, sq);
      inv = gmul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [127:0] sub_bytes(input logic [127:0] st);
    logic [127:0] o;
    o = '0;
    for (int i = 0; i < 16; i++) o[8*i +: 8] = sbox(st[8*i +: 8]);
    return o;
  endfunction

  function automatic logic [127:0] shift_rows(input logic [127:0] st);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(r+4*c) -: 8] = st[127-8*(r+4*((c+r)%4)) -: 8];
    return o;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] st);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = st[127-32*c -: 8];
      a1 = st[119-32*c -: 8];
      a2 = st[111-32*c -: 8];
      a3 = st[103-32*c -: 8];
      o[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      o[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      o[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      o[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
    return o;
  endfunction

  function automatic logic [127:0] next_key(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] t, n0, n1, n2, n3;
    t  = {sbox(k[23:16]), sbox(k[15:8]), sbox(k[7:0]), sbox(k[31:24])} ^ {rc, 24'h0};
    n0 = k[127:96] ^ t;
    n1 = k[95:64] ^ n0;
    n2 = k[63:32] ^ n1;
    n3 = k[31:0] ^ n2;
    return {n0, n1, n2, n3};
  endfunction

  logic [127:0] w_state;
  logic [127:0] w_rkey;
  logic [7:0]   w_rcon;

  always_comb begin
    w_rkey  = i_key;
    w_state = i_plain ^ i_key;
    w_rcon  = 8'h01;
    for (int r = 1; r <= 10; r++) begin
      w_rkey  = next_key(w_rkey, w_rcon);
      w_rcon  = xtime(w_rcon);
      w_state = shift_rows(sub_bytes(w_state));
      if (r != 10) w_state = mix_columns(w_state);
      w_state = w_state ^ w_rkey;
    end
  end

  assign o_cipher = w_state;

endmodule

// File: rtl/aes_out_fifo.sv
// rtl/aes_out_fifo.sv - tagged result FIFO; full/empty come from the occupancy count, pointers wrap freely
module aes_out_fifo
  import aes_wrap_pkg::*;
#(
  parameter int  DEPTH = 4,
  parameter type T     = logic [7:0]
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         i_wr_valid,
  input  T                             i_wr_data,
  input  logic                         i_rd_ready,
  output logic                         o_rd_valid,
  output T                             o_rd_data,
  output logic [fifo_cnt_w(DEPTH)-1:0] o_count
);

  localparam int PTR_W = ptr_w(DEPTH);
  localparam int CW    = fifo_cnt_w(DEPTH);

  T                 r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_pop;

  assign o_rd_valid = (r_count != '0);
  assign w_pop      = o_rd_valid && i_rd_ready;
  assign o_count    = r_count;

  always_comb begin
    o_rd_data = '0;
    if (o_rd_valid) o_rd_data = r_mem[r_rd_ptr];
  end

  // Upstream credit accounting guarantees a write never lands on a full FIFO
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_wr_valid) begin
        r_mem[r_wr_ptr] <= i_wr_data;
        r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      r_count <= r_count + CW'(i_wr_valid) - CW'(w_pop);
    end
  end

endmodule

// File: rtl/aes_stream_wrapper.sv
// rtl/aes_stream_wrapper.sv - streaming AES-128 wrapper with retiming stages and credit-gated output FIFO
// Optional AES_KEY_HOLD_EN: persistent key register loaded via key_load while idle.
module aes_stream_wrapper
  import aes_wrap_pkg::*;
#(
  parameter int LATENCY    = 1,
  parameter int FIFO_DEPTH = 4,
  parameter int TAG_W      = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [AES_BLK_W-1:0] in_plain,
  input  logic [AES_KEY_W-1:0] in_key,
  input  logic [TAG_W-1:0]     in_tag,
`ifdef AES_KEY_HOLD_EN
  input  logic                 key_load,
  output logic                 key_ready,
`endif
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [AES_BLK_W-1:0] out_cipher,
  output logic [TAG_W-1:0]     out_tag,
  output logic                 busy
);

  localparam int CNT_W  = cnt_w(FIFO_DEPTH, LATENCY);
  localparam int FCNT_W = fifo_cnt_w(FIFO_DEPTH);

  // Tag width is a module parameter, so the payload types are sized here
  typedef struct packed {
    logic [AES_BLK_W-1:0] plain;
    logic [AES_KEY_W-1:0] key;
    logic [TAG_W-1:0]     tag;
  } beat_t;

  typedef struct packed {
    logic [AES_BLK_W-1:0] cipher;
    logic [TAG_W-1:0]     tag;
  } res_t;

  logic                 r_s0_valid;
  beat_t                r_s0_beat;
  logic [LATENCY-1:0]   r_pipe_valid;
  res_t                 r_pipe_res [LATENCY];
  logic [CNT_W-1:0]     r_inflight;
  logic                 w_accept;
  logic [AES_KEY_W-1:0] w_beat_key;
  logic [AES_BLK_W-1:0] w_core_cipher;
  logic [FCNT_W-1:0]    w_fifo_count;
  logic [CNT_W-1:0]     w_credit_used;
  res_t                 w_head;

  assign w_credit_used = r_inflight + CNT_W'(w_fifo_count);
  assign in_ready      = !rst && (w_credit_used < CNT_W'(FIFO_DEPTH));
  assign w_accept      = in_valid && in_ready;
  assign busy          = (r_inflight != '0) || (w_fifo_count != '0);

`ifdef AES_KEY_HOLD_EN
  logic [AES_KEY_W-1:0] r_held_key;

  assign w_beat_key = r_held_key;
  assign key_ready  = !busy;

  always_ff @(posedge clk) begin
    if (rst) r_held_key <= '0;
    else if (key_load && !busy) r_held_key <= in_key;
  end
`else
  assign w_beat_key = in_key;
`endif

  AES_Encrypt u_core (
    .i_plain  (r_s0_beat.plain),
    .i_key    (r_s0_beat.key),
    .o_cipher (w_core_cipher)
  );

  // Retiming stages shift every cycle; the credit check keeps the FIFO from ever refusing them
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s0_valid   <= 1'b0;
      r_s0_beat    <= '0;
      r_pipe_valid <= '0;
      r_inflight   <= '0;
      for (int i = 0; i < LATENCY; i++) r_pipe_res[i] <= '0;
    end else begin
      r_s0_valid <= w_accept;
      if (w_accept) begin
        r_s0_beat.plain <= in_plain;
        r_s0_beat.key   <= w_beat_key;
        r_s0_beat.tag   <= in_tag;
      end
      r_pipe_valid[0]      <= r_s0_valid;
      r_pipe_res[0].cipher <= w_core_cipher;
      r_pipe_res[0].tag    <= r_s0_beat.tag;
      for (int i = 1; i < LATENCY; i++) begin
        r_pipe_valid[i] <= r_pipe_valid[i-1];
        r_pipe_res[i]   <= r_pipe_res[i-1];
      end
      r_inflight <= r_inflight + CNT_W'(w_accept) - CNT_W'(r_pipe_valid[LATENCY-1]);
    end
  end

  aes_out_fifo #(
    .DEPTH (FIFO_DEPTH),
    .T     (res_t)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .i_wr_valid (r_pipe_valid[LATENCY-1]),
    .i_wr_data  (r_pipe_res[LATENCY-1]),
    .i_rd_ready (out_ready),
    .o_rd_valid (out_valid),
    .o_rd_data  (w_head),
    .o_count    (w_fifo_count)
  );

  assign out_cipher = w_head.cipher;
  assign out_tag    = w_head.tag;

endmodule

// File: tb/tb_aes_stream_wrapper.sv
// tb/tb_aes_stream_wrapper.sv - scoreboard bench for aes_stream_wrapper against known-answer AES vectors
module tb_aes_stream_wrapper;

  localparam int LAT   = 1;
  localparam int DEPTH = 4;
  localparam int TW    = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [127:0]  in_plain;
  logic [127:0]  in_key;
  logic [TW-1:0] in_tag;
  logic          out_valid;
  logic          out_ready;
  logic [127:0]  out_cipher;
  logic [TW-1:0] out_tag;
  logic          busy;
`ifdef AES_KEY_HOLD_EN
  logic          key_load;
  logic          key_ready;
`endif

  always #5 clk = ~clk;

  aes_stream_wrapper #(
    .LATENCY    (LAT),
    .FIFO_DEPTH (DEPTH),
    .TAG_W      (TW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_plain   (in_plain),
    .in_key     (in_key),
    .in_tag     (in_tag),
`ifdef AES_KEY_HOLD_EN
    .key_load   (key_load),
    .key_ready  (key_ready),
`endif
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_cipher (out_cipher),
    .out_tag    (out_tag),
    .busy       (busy)
  );

  // Reference model: published AES-128 known-answer vectors
  logic [127:0] PT  [4];
  logic [127:0] KEY [4];
  logic [127:0] CT  [4];

  logic [131:0] exp_q [$];
  logic [131:0] cur_exp;
  logic [131:0] mon_exp;
  int           checks = 0;
  int           errors = 0;

  task automatic check(input string name, input logic [131:0] got, input logic [131:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: got %h expected no output", {out_cipher, out_tag});
      end else if (out_ready) begin
        mon_exp = exp_q.pop_front();
        check("result", {out_cipher, out_tag}, mon_exp);
      end else begin
        check("stall_head", {out_cipher, out_tag}, exp_q[0]);
      end
    end
  end

  task automatic load_beat(input int v, input logic [TW-1:0] tag);
    in_plain = PT[v];
    in_key   = KEY[v];
    in_tag   = tag;
    cur_exp  = {CT[v], tag};
  endtask

  task automatic send_one(input logic [127:0] plain, input logic [127:0] key,
                          input logic [TW-1:0] tag, input logic [127:0] exp_ct);
    bit done = 0;
    in_plain = plain;
    in_key   = key;
    in_tag   = tag;
    in_valid = 1'b1;
    for (int c = 0; c < 50 && !done; c++) begin
      @(negedge clk);
      if (in_ready) begin
        exp_q.push_back({exp_ct, tag});
        done = 1;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: accepted 0 of 1");
    end
  endtask

  task automatic run_stream(input int n, input bit alt, input int vpct, input int rpct,
                            input bit must_ready, output int cyc);
    int sent = 0;
    bit pending = 0;
    int v;
    cyc = 0;
    while (sent < n && cyc < 2000) begin
      if (!pending && $urandom_range(0, 99) < vpct) begin
        v = alt ? (sent % 2) : int'($urandom_range(0, 3));
        load_beat(v, alt ? TW'(sent) : TW'($urandom));
        pending = 1;
      end
      in_valid  = pending;
      out_ready = ($urandom_range(0, 99) < rpct);
      @(negedge clk);
      if (must_ready && pending) check("in_ready_stream", in_ready, 1'b1);
      if (pending && in_ready) begin
        exp_q.push_back(cur_exp);
        sent++;
        pending = 0;
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    in_valid = 1'b0;
    if (sent < n) begin
      checks++;
      errors++;
      $display("FAIL stream_timeout: accepted %0d of %0d", sent, n);
    end
  endtask

  task automatic drain();
    int c = 0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    while (exp_q.size() != 0 && c < 300) begin
      @(posedge clk);
      #1;
      c++;
    end
    check("drain_all_results", exp_q.size(), 0);
    @(negedge clk);
    check("drain_busy", busy, 1'b0);
    check("drain_out_valid", out_valid, 1'b0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int cyc_used;
    PT[0] = 128'h00112233445566778899aabbccddeeff;
    KEY[0] = 128'h000102030405060708090a0b0c0d0e0f;
    CT[0] = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    PT[1] = 128'h3243f6a8885a308d313198a2e0370734;
    KEY[1] = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    CT[1] = 128'h3925841d02dc09fbdc118597196a0b32;
    PT[2] = 128'h6bc1bee22e409f96e93d7e117393172a;
    KEY[2] = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    CT[2] = 128'h3ad77bb40d7a3660a89ecaf32466ef97;
    PT[3] = 128'h0;
    KEY[3] = 128'h0;
    CT[3] = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_plain  = '0;
    in_key    = '0;
    in_tag    = '0;
    out_ready = 1'b0;
`ifdef AES_KEY_HOLD_EN
    key_load  = 1'b0;
`endif

    @(negedge clk);
    check("in_ready_in_reset", in_ready, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_out_valid", out_valid, 1'b0);
    check("reset_busy", busy, 1'b0);
    check("reset_out_cipher", out_cipher, 128'h0);
    check("reset_out_tag", out_tag, 0);
    check("reset_in_ready", in_ready, 1'b1);
    @(posedge clk);
    #1;

`ifndef AES_KEY_HOLD_EN
    // Single C.1 beat: out_valid must appear exactly LAT+1 edges after acceptance
    out_ready = 1'b1;
    send_one(PT[0], KEY[0], 4'd3, CT[0]);
    for (int j = 0; j <= LAT; j++) begin
      @(negedge clk);
      check("latency_not_yet", out_valid, 1'b0);
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    check("latency_valid", out_valid, 1'b1);
    @(posedge clk);
    #1;
    drain();

    // Back-to-back alternating vectors, tags 0..15
    run_stream(16, 1'b1, 100, 100, 1'b1, cyc_used);
    check("b2b_cycles", cyc_used, 16);
    drain();

    // Backpressure: exactly DEPTH accepted, then held off until drained
    run_stream(DEPTH, 1'b0, 100, 0, 1'b0, cyc_used);
    load_beat(1, 4'hf);
    in_valid = 1'b1;
    for (int j = 0; j < 10; j++) begin
      @(negedge clk);
      check("bp_in_ready_low", in_ready, 1'b0);
      check("bp_busy", busy, 1'b1);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    drain();
    run_stream(4, 1'b0, 100, 100, 1'b1, cyc_used);
    drain();

    // Start full, then push and pop together for 40 beats
    run_stream(DEPTH, 1'b0, 100, 0, 1'b0, cyc_used);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    run_stream(40, 1'b0, 100, 100, 1'b0, cyc_used);
    checks++;
    if (cyc_used > 42) begin
      errors++;
      $display("FAIL full_throughput: got %0d cycles expected at most 42", cyc_used);
    end
    drain();

    // Reset with beats both in flight and buffered: all of them must vanish
    run_stream(DEPTH, 1'b0, 100, 0, 1'b0, cyc_used);
    rst = 1'b1;
    exp_q.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("midreset_out_valid", out_valid, 1'b0);
    check("midreset_busy", busy, 1'b0);
    check("midreset_out_cipher", out_cipher, 128'h0);
    check("midreset_in_ready", in_ready, 1'b1);
    out_ready = 1'b1;
    repeat (10) begin
      @(posedge clk);
      #1;
    end
    run_stream(3, 1'b0, 100, 100, 1'b0, cyc_used);
    drain();

    // Randomized valid/ready traffic
    run_stream(200, 1'b0, 70, 60, 1'b0, cyc_used);
    drain();
`else
    // Held-key build: load once while idle, then beats carry in_key=0
    key_load = 1'b1;
    in_key   = KEY[1];
    @(negedge clk);
    check("key_ready_idle", key_ready, 1'b1);
    @(posedge clk);
    #1 key_load = 1'b0;
    in_key = '0;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) send_one(PT[1], 128'h0, TW'(i), CT[1]);
    key_load = 1'b1;
    in_key   = KEY[0];
    @(negedge clk);
    check("key_ready_busy", key_ready, 1'b0);
    @(posedge clk);
    #1 key_load = 1'b0;
    in_key = '0;
    drain();
    send_one(PT[1], 128'h0, 4'h9, CT[1]);
    drain();
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
